rx_frame_reader: RTL and testbench
==================================

RX_FRAME_READER -- requirements
Module: rx_frame_reader

Interface
REQ-001 Parameter DATA_W, default 16: data bus width to the Ethernet controller; legal values 8 and 16.
REQ-002 Parameter MAX_LEN, default 1536: largest accepted frame length in bytes.
REQ-003 Parameter TIMEOUT_CYC, default 1023: watchdog limit in cycles, width 16.
REQ-004 Clock  in  1  single clock; all state updates on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 req_in  in  1  user frame-read request; level, held for the whole transfer.
REQ-007 grant_in  in  1  bus grant from the arbitrator.
REQ-008 enet_rdy_in  in  1  Ethernet controller command complete; datar_in is valid in the same cycle.
REQ-009 datar_in  in  DATA_W  read data from the Ethernet controller.
REQ-010 data_rdy_in  in  1  downstream accepts data_out.
REQ-011 req_out  out  1  bus request to the arbitrator.
REQ-012 addr_out  out  8  register address to the Ethernet controller.
REQ-013 start_comm_out  out  1  one-cycle command strobe.
REQ-014 comm_type_out  out  2  command type: 0 = READ, 3 = RX.
REQ-015 data_out / data_vld_out  out  DATA_W / 1  registered payload word and its valid flag.
REQ-016 status_out / len_out  out  16 / 16  captured RX status and byte length.
REQ-017 done_out  out  1  one-cycle pulse at transfer end, including abort.
REQ-018 err_out / err_code_out  out  1 / 2  one-cycle error pulse and its code.

Function
REQ-019 States: IDLE, GRANT, POLL, CHK, STAT, LEN, DISSUE, DWAIT, DHOLD, DONE, ERR.
REQ-020 req_out SHALL be 1 in every state except IDLE, DONE and ERR.
REQ-021 IDLE->GRANT on req_in=1; GRANT->POLL on grant_in=1.
REQ-022 Each register read: strobe start_comm_out in the issue cycle with comm_type_out=0; wait for enet_rdy_in; capture datar_in in the enet_rdy_in cycle.
REQ-023 POLL reads address 0xF0; CHK goes to STAT if the captured bit 0 is 1, else to ERR with code 1.
REQ-024 STAT reads address 0xF2 into status_out; LEN reads address 0xF2 into len_out.
REQ-025 When DATA_W=8, STAT and LEN each take two reads: low byte first, then high byte.
REQ-026 Length 0 or length > MAX_LEN -> ERR with code 2; no data reads are issued.
REQ-027 Word count = ceil(len_out*8/DATA_W); exactly that many RX reads are issued (index < count; no off-by-one extra read).
REQ-028 DISSUE: strobe with addr_out=0xF2 and comm_type_out=3, then go to DWAIT.
REQ-029 DWAIT: on enet_rdy_in, register datar_in into data_out, set data_vld_out, go to DHOLD.
REQ-030 DHOLD: hold data_out and data_vld_out until data_rdy_in=1; clear valid on acceptance; go to DISSUE, or to DONE after the last word.
REQ-031 req_in=0 observed in DISSUE or DHOLD (after acceptance) -> DONE; no further strobes; error stays 0.
REQ-032 DONE pulses done_out for 1 cycle and returns to IDLE. ERR pulses err_out and done_out for 1 cycle and returns to IDLE.
REQ-033 addr_out and comm_type_out SHALL be 0 whenever start_comm_out=0.
REQ-034 grant_in SHALL be sampled only in GRANT.
REQ-035 status_out and len_out SHALL hold their values until the next POLL.

Reset
REQ-036 Reset=1 SHALL immediately force state IDLE and all outputs and counters to 0, including mid-transfer.
REQ-037 After reset deasserts, the first command SHALL be issued only after a fresh req_in/grant_in sequence.

Configuration
REQ-038 Macro RXF_TIMEOUT_EN, when defined: a watchdog counts consecutive cycles spent waiting for enet_rdy_in and resets on each enet_rdy_in; reaching TIMEOUT_CYC -> ERR with code 3.
REQ-039 Without RXF_TIMEOUT_EN: no watchdog logic; waits are unbounded and code 3 is never produced.

Verification
REQ-040 DATA_W=16, F0=0x0001, status=0x1234, len=6 -> 3 RX strobes; data words in order; status_out=0x1234; len_out=6; one done_out pulse.
REQ-041 DATA_W=8, len=5 -> 2+2 register reads, then exactly 5 RX strobes; len_out=0x0005.
REQ-042 F0=0x0000 -> err_code_out=1, err_out pulse, no 0xF2 reads; MAX_LEN=64 with len=65 -> code 2.
REQ-043 data_rdy_in held at 0 for 10 cycles on word 2 -> data_out stable, no strobe issued; release -> next strobe the following cycle.
REQ-044 req_in dropped after word 1 of 4 -> done_out pulse, err_out=0, no further strobes.
REQ-045 RXF_TIMEOUT_EN, TIMEOUT_CYC=20, enet_rdy_in stuck at 0 -> code 3 after 20 cycles; Reset mid-DWAIT -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/rx_frame_reader_if.sv
// Handshake/bus bundle for rx_frame_reader: user request, arbitration,
// Ethernet controller command port and downstream payload/status outputs.
interface rx_frame_reader_if #(
    parameter int unsigned DATA_W = 16
);
    logic              req_in;
    logic              grant_in;
    logic              enet_rdy_in;
    logic [DATA_W-1:0] datar_in;
    logic              data_rdy_in;
    logic              req_out;
    logic [7:0]        addr_out;
    logic              start_comm_out;
    logic [1:0]        comm_type_out;
    logic [DATA_W-1:0] data_out;
    logic              data_vld_out;
    logic [15:0]       status_out;
    logic [15:0]       len_out;
    logic              done_out;
    logic              err_out;
    logic [1:0]        err_code_out;

    // Reader side: issues bus requests and controller commands.
    modport master (
        input  req_in, grant_in, enet_rdy_in, datar_in, data_rdy_in,
        output req_out, addr_out, start_comm_out, comm_type_out,
               data_out, data_vld_out, status_out, len_out,
               done_out, err_out, err_code_out
    );

    modport slave (
        output req_in, grant_in, enet_rdy_in, datar_in, data_rdy_in,
        input  req_out, addr_out, start_comm_out, comm_type_out,
               data_out, data_vld_out, status_out, len_out,
               done_out, err_out, err_code_out
    );
endinterface

// File: rtl/rx_frame_reader.sv
// Reads one received frame from the Ethernet controller: poll, status, length, payload.
// Optional enet_rdy_in watchdog (error code 3) is built only when RXF_TIMEOUT_EN is defined.
module rx_frame_reader #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned MAX_LEN     = 1536,
    parameter logic [15:0] TIMEOUT_CYC = 16'd1023
) (
    input logic          Clock,
    input logic          Reset,
    rx_frame_reader_if.master bus
);
    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] GRANT  = 4'd1;
    localparam logic [3:0] POLL   = 4'd2;
    localparam logic [3:0] CHK    = 4'd3;
    localparam logic [3:0] STAT   = 4'd4;
    localparam logic [3:0] LEN    = 4'd5;
    localparam logic [3:0] DISSUE = 4'd6;
    localparam logic [3:0] DWAIT  = 4'd7;
    localparam logic [3:0] DHOLD  = 4'd8;
    localparam logic [3:0] DONE   = 4'd9;
    localparam logic [3:0] ERR    = 4'd10;

    localparam logic [7:0]  ADDR_POLL = 8'hF0;
    localparam logic [7:0]  ADDR_DATA = 8'hF2;
    localparam logic [1:0]  CT_READ   = 2'd0;
    localparam logic [1:0]  CT_RX     = 2'd3;
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
    localparam bit          TWO_PART  = (DATA_W == 8);

    logic [3:0]        state;
    logic              issued;
    logic              byte_hi;
    logic              poll_ok;
    logic [15:0]       word_idx;
    logic [1:0]        err_code;
    logic [DATA_W-1:0] data_r;
    logic              data_vld_r;
    logic [15:0]       status_r;
    logic [15:0]       len_r;

    logic [15:0] rd16;
    logic [15:0] stat_next;
    logic [15:0] len_next;
    logic        last_part;
    logic        len_bad;
    logic [15:0] word_cnt;
    logic        reg_read;
    logic        waiting;
    logic        strobe;
    logic        wd_expire;

    assign rd16      = 16'(bus.datar_in);
    // On an 8-bit bus the low byte lands first; the high byte completes the value.
    assign stat_next = TWO_PART ? {rd16[7:0], status_r[7:0]} : rd16;
    assign len_next  = TWO_PART ? {rd16[7:0], len_r[7:0]} : rd16;
    assign last_part = !TWO_PART || byte_hi;
    assign len_bad   = (len_next == '0) || (len_next > MAX_LEN_W);
    assign word_cnt  = TWO_PART ? len_r : 16'((17'(len_r) + 17'd1) >> 1);

    assign reg_read = (state == POLL) || (state == STAT) || (state == LEN);
    assign waiting  = (reg_read && issued) || (state == DWAIT);
    assign strobe   = (reg_read && !issued) || ((state == DISSUE) && bus.req_in);

`ifdef RXF_TIMEOUT_EN
    logic [15:0] wd_cnt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wd_cnt <= '0;
        end else if (!waiting || bus.enet_rdy_in) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end

    assign wd_expire = waiting && !bus.enet_rdy_in && (wd_cnt >= (TIMEOUT_CYC - 16'd1));
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            issued     <= 1'b0;
            byte_hi    <= 1'b0;
            poll_ok    <= 1'b0;
            word_idx   <= '0;
            err_code   <= '0;
            data_r     <= '0;
            data_vld_r <= 1'b0;
            status_r   <= '0;
            len_r      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_in) state <= GRANT;
                end
                GRANT: begin
                    if (bus.grant_in) begin
                        state    <= POLL;
                        issued   <= 1'b0;
                        byte_hi  <= 1'b0;
                        status_r <= '0;
                        len_r    <= '0;
                    end
                end
                POLL: begin
                    if (!issued) begin
                        issued <= 1'b1;
                    end else if (bus.enet_rdy_in) begin
                        poll_ok <= rd16[0];
                        issued  <= 1'b0;
                        state   <= CHK;
                    end else if (wd_expire) begin
                        err_code <= 2'd3;
                        state    <= ERR;
                    end
                end
                CHK: begin
                    if (poll_ok) begin
                        state <= STAT;
                    end else begin
                        err_code <= 2'd1;
                        state    <= ERR;
                    end
                end
                STAT: begin
                    if (!issued) begin
                        issued <= 1'b1;
                    end else if (bus.enet_rdy_in) begin
                        issued <= 1'b0;
                        if (last_part) begin
                            status_r <= stat_next;
                            byte_hi  <= 1'b0;
                            state    <= LEN;
                        end else begin
                            status_r <= {8'h00, rd16[7:0]};
                            byte_hi  <= 1'b1;
                        end
                    end else if (wd_expire) begin
                        err_code <= 2'd3;
                        state    <= ERR;
                    end
                end
                LEN: begin
                    if (!issued) begin
                        issued <= 1'b1;
                    end else if (bus.enet_rdy_in) begin
                        issued <= 1'b0;
                        if (last_part) begin
                            len_r   <= len_next;
                            byte_hi <= 1'b0;
                            word_idx <= '0;
                            if (len_bad) begin
                                err_code <= 2'd2;
                                state    <= ERR;
                            end else begin
                                state <= DISSUE;
                            end
                        end else begin
                            len_r   <= {8'h00, rd16[7:0]};
                            byte_hi <= 1'b1;
                        end
                    end else if (wd_expire) begin
                        err_code <= 2'd3;
                        state    <= ERR;
                    end
                end
                DISSUE: begin
                    state <= bus.req_in ? DWAIT : DONE;
                end
                DWAIT: begin
                    if (bus.enet_rdy_in) begin
                        data_r     <= bus.datar_in;
                        data_vld_r <= 1'b1;
                        word_idx   <= word_idx + 16'd1;
                        state      <= DHOLD;
                    end else if (wd_expire) begin
                        err_code <= 2'd3;
                        state    <= ERR;
                    end
                end
                DHOLD: begin
                    if (bus.data_rdy_in) begin
                        data_vld_r <= 1'b0;
                        state      <= ((word_idx >= word_cnt) || !bus.req_in) ? DONE : DISSUE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                ERR: begin
                    err_code <= '0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_out        = !((state == IDLE) || (state == DONE) || (state == ERR));
    assign bus.start_comm_out = strobe;
    assign bus.addr_out       = !strobe ? 8'h00 : ((state == POLL) ? ADDR_POLL : ADDR_DATA);
    assign bus.comm_type_out  = (strobe && (state == DISSUE)) ? CT_RX : CT_READ;
    assign bus.data_out       = data_r;
    assign bus.data_vld_out   = data_vld_r;
    assign bus.status_out     = status_r;
    assign bus.len_out        = len_r;
    assign bus.done_out       = (state == DONE) || (state == ERR);
    assign bus.err_out        = (state == ERR);
    assign bus.err_code_out   = (state == ERR) ? err_code : 2'd0;
endmodule

// File: tb/tb_rx_frame_reader.sv
// Randomized self-checking bench for rx_frame_reader: 16-bit (MAX_LEN=64) and 8-bit instances
// driven one at a time and compared against a frame-level reference model.
module tb_rx_frame_reader;
    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    logic        sel;
    logic        req, grant, enet_rdy, data_rdy;
    logic [15:0] datar;

    rx_frame_reader_if #(.DATA_W(16)) if16 ();
    rx_frame_reader_if #(.DATA_W(8))  if8 ();

    rx_frame_reader #(.DATA_W(16), .MAX_LEN(64), .TIMEOUT_CYC(16'd20)) u_dut16 (
        .Clock(Clock), .Reset(Reset), .bus(if16)
    );
    rx_frame_reader #(.DATA_W(8), .MAX_LEN(1536), .TIMEOUT_CYC(16'd20)) u_dut8 (
        .Clock(Clock), .Reset(Reset), .bus(if8)
    );

    assign if16.req_in      = req && !sel;
    assign if16.grant_in    = grant && !sel;
    assign if16.enet_rdy_in = enet_rdy && !sel;
    assign if16.datar_in    = datar;
    assign if16.data_rdy_in = data_rdy && !sel;
    assign if8.req_in       = req && sel;
    assign if8.grant_in     = grant && sel;
    assign if8.enet_rdy_in  = enet_rdy && sel;
    assign if8.datar_in     = datar[7:0];
    assign if8.data_rdy_in  = data_rdy && sel;

    logic        o_req, o_strobe, o_vld, o_done, o_err;
    logic [7:0]  o_addr;
    logic [1:0]  o_type, o_code;
    logic [15:0] o_data, o_status, o_len;

    always_comb begin
        if (sel) begin
            o_req = if8.req_out; o_strobe = if8.start_comm_out; o_addr = if8.addr_out;
            o_type = if8.comm_type_out; o_data = {8'h00, if8.data_out}; o_vld = if8.data_vld_out;
            o_status = if8.status_out; o_len = if8.len_out; o_done = if8.done_out;
            o_err = if8.err_out; o_code = if8.err_code_out;
        end else begin
            o_req = if16.req_out; o_strobe = if16.start_comm_out; o_addr = if16.addr_out;
            o_type = if16.comm_type_out; o_data = if16.data_out; o_vld = if16.data_vld_out;
            o_status = if16.status_out; o_len = if16.len_out; o_done = if16.done_out;
            o_err = if16.err_out; o_code = if16.err_code_out;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One frame: reference expectations are built up front from the frame contents,
    // then a cycle loop plays arbiter, controller and downstream sink.
    task automatic run_frame(input bit s, input logic [15:0] f0, input logic [15:0] st,
                             input logic [15:0] ln, input int drop_after, input int stall_word,
                             input bit stuck);
        logic [15:0] resp[$];
        logic [9:0]  cmds[$];
        logic [15:0] words[$];
        logic [15:0] mask, hold_val;
        int w, maxl, code, nwords, nrx, gdly, dly, cyc, acc, idle_bad, stall_cnt, strobe_cyc, quiet;
        bit pending, got_done, exp_strobe, hold_active;

        w = s ? 8 : 16;
        maxl = s ? 1536 : 64;
        mask = s ? 16'h00FF : 16'hFFFF;
        nwords = 0; nrx = 0;
        resp.push_back(f0);
        cmds.push_back({2'd0, 8'hF0});
        if (stuck) begin
            code = 3;
        end else if (!f0[0]) begin
            code = 1;
        end else begin
            if (s) begin
                resp.push_back({8'h00, st[7:0]}); resp.push_back({8'h00, st[15:8]});
                resp.push_back({8'h00, ln[7:0]}); resp.push_back({8'h00, ln[15:8]});
                repeat (4) cmds.push_back({2'd0, 8'hF2});
            end else begin
                resp.push_back(st); resp.push_back(ln);
                repeat (2) cmds.push_back({2'd0, 8'hF2});
            end
            if (ln == 0 || int'(ln) > maxl) begin
                code = 2;
            end else begin
                code = 0;
                nwords = (int'(ln) * 8 + w - 1) / w;
                nrx = (drop_after > 0 && drop_after < nwords) ? drop_after : nwords;
                for (int i = 0; i < nwords; i++) words.push_back(16'($urandom) & mask);
                for (int i = 0; i < nrx; i++) begin
                    resp.push_back(words[i]);
                    cmds.push_back({2'd3, 8'hF2});
                end
            end
        end

        sel = s; req = 1'b1; grant = 1'b0; enet_rdy = 1'b0; data_rdy = 1'b0;
        gdly = $urandom_range(0, 3);
        pending = 0; dly = 0; cyc = 0; acc = 0; idle_bad = 0; stall_cnt = 0; strobe_cyc = 0;
        got_done = 0; exp_strobe = 0; hold_active = 0; hold_val = '0;

        while (!got_done && cyc < 4000) begin
            @(negedge Clock);
            cyc++;
            if (o_req) begin
                if (gdly == 0) grant = 1'b1;
                else gdly--;
            end
            enet_rdy = 1'b0;
            datar = 16'($urandom);
            if (pending && !stuck) begin
                if (dly == 0) begin
                    enet_rdy = 1'b1;
                    datar = (resp.size() != 0) ? resp.pop_front() : 16'hDEAD;
                    pending = 0;
                end else begin
                    dly--;
                end
            end
            if (o_vld && acc == stall_word && stall_cnt < 10) begin
                data_rdy = 1'b0;
                stall_cnt++;
            end else begin
                data_rdy = ($urandom_range(0, 2) != 0);
            end
            req = !(drop_after > 0 && acc >= drop_after);
            #1;
            if (hold_active) check("hold_data", {15'd0, o_vld, o_data}, {15'd0, 1'b1, hold_val});
            if (exp_strobe) check("strobe_after_accept", o_strobe, 1'b1);
            exp_strobe = 0;
            if (o_strobe) begin
                check("cmd", {22'd0, o_type, o_addr}, (cmds.size() != 0) ? {22'd0, cmds.pop_front()} : 32'h3FF);
                pending = 1;
                dly = $urandom_range(0, 2);
                strobe_cyc = cyc;
            end else if (o_addr != 8'h00 || o_type != 2'd0) begin
                idle_bad++;
            end
            hold_active = o_vld && !data_rdy;
            hold_val = o_data;
            if (o_vld && data_rdy) begin
                check("data", o_data, (acc < nwords) ? words[acc] : 16'hBEEF);
                acc++;
                exp_strobe = (acc < nwords) && !(drop_after > 0 && acc >= drop_after);
            end
            if (o_done) begin
                got_done = 1;
                check("err_out", o_err, code != 0);
                check("err_code", o_code, code);
                check("req_at_done", o_req, 1'b0);
                if (code == 0 || code == 2) begin
                    check("status_out", o_status, st);
                    check("len_out", o_len, ln);
                end
                if (stuck) check("timeout_latency", cyc - strobe_cyc, 21);
            end
        end
        if (!got_done) check("done_seen", 0, 1);
        check("cmds_left", cmds.size(), 0);
        check("words_accepted", acc, nrx);
        check("addr_idle_zero", idle_bad, 0);

        req = 1'b0; grant = 1'b0; enet_rdy = 1'b0; data_rdy = 1'b0;
        @(negedge Clock); #1;
        check("done_one_cycle", o_done, 1'b0);
        quiet = 0;
        repeat (3) begin
            @(negedge Clock); #1;
            if (o_strobe || o_req) quiet++;
        end
        check("quiet_after_done", quiet, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [15:0] rresp[$];
        int dropv, lmax, cnt;
        bit s, pend, hit;
        logic [15:0] lv;

        Reset = 1'b1; sel = 1'b0; req = 1'b0; grant = 1'b0;
        enet_rdy = 1'b0; data_rdy = 1'b0; datar = '0;
        repeat (3) @(negedge Clock);
        #1;
        check("reset_outs16", |{o_req, o_strobe, o_addr, o_type, o_data, o_vld, o_status, o_len, o_done, o_err, o_code}, 1'b0);
        sel = 1'b1; #1;
        check("reset_outs8", |{o_req, o_strobe, o_addr, o_type, o_data, o_vld, o_status, o_len, o_done, o_err, o_code}, 1'b0);
        sel = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;

        run_frame(0, 16'h0001, 16'h1234, 16'd6, -1, -1, 0);
        run_frame(0, 16'h0001, 16'hA5C3, 16'd8, -1, 1, 0);
        run_frame(0, 16'h0001, 16'h0F0F, 16'd8, 1, -1, 0);
        run_frame(0, 16'h0000, 16'h1111, 16'd6, -1, -1, 0);
        run_frame(0, 16'h0003, 16'h2222, 16'd65, -1, -1, 0);
        run_frame(0, 16'h0001, 16'h3333, 16'd0, -1, -1, 0);
        run_frame(0, 16'h0001, 16'h4444, 16'd64, -1, -1, 0);
        run_frame(0, 16'h0001, 16'h5555, 16'd1, -1, -1, 0);
        run_frame(1, 16'h0001, 16'hBEAD, 16'd5, -1, -1, 0);
        run_frame(1, 16'h00FE, 16'h6666, 16'd5, -1, -1, 0);
        run_frame(1, 16'h0001, 16'h7777, 16'd1537, -1, -1, 0);
        run_frame(1, 16'h0001, 16'h8888, 16'd1, -1, 2, 0);

        for (int i = 0; i < 14; i++) begin
            s = 1'($urandom_range(0, 1));
            lmax = s ? 40 : 72;
            lv = 16'($urandom_range(0, lmax));
            dropv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : -1;
            run_frame(s, {15'($urandom), ($urandom_range(0, 5) != 0)}, 16'($urandom), lv,
                      dropv, int'($urandom_range(0, 3)), 0);
        end

        // Reset asserted while the 16-bit reader waits on its first RX word.
        sel = 1'b0; req = 1'b1; grant = 1'b1; data_rdy = 1'b0;
        rresp = '{16'h0001, 16'h1234, 16'h0006};
        pend = 0; hit = 0; cnt = 0;
        while (!hit && cnt < 200) begin
            @(negedge Clock);
            cnt++;
            enet_rdy = pend;
            datar = (pend && rresp.size() != 0) ? rresp.pop_front() : 16'h0000;
            pend = 0;
            #1;
            if (o_strobe) begin
                if (o_type == 2'd3) hit = 1;
                else pend = 1;
            end
        end
        check("reached_dissue", hit, 1'b1);
        enet_rdy = 1'b0;
        @(posedge Clock); #1;
        check("dwait_req_out", o_req, 1'b1);
        check("dwait_status", o_status, 16'h1234);
        #1 Reset = 1'b1;
        #1;
        check("async_reset_outs", |{o_req, o_strobe, o_addr, o_type, o_data, o_vld, o_status, o_len, o_done, o_err, o_code}, 1'b0);
        @(negedge Clock);
        Reset = 1'b0; req = 1'b1; grant = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge Clock); #1;
            if (o_strobe) cnt++;
        end
        check("no_cmd_without_grant", cnt, 0);
        check("req_out_waiting_grant", o_req, 1'b1);
        Reset = 1'b1; req = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;

`ifdef RXF_TIMEOUT_EN
        run_frame(0, 16'h0001, 16'h0000, 16'd0, -1, -1, 1);
        run_frame(1, 16'h0001, 16'h0000, 16'd0, -1, -1, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
